// File: rtl/io_port_pkg.sv
// Shared constants, address map and status layout for the memory-mapped I/O port.
// The address decode helper maps a bus address onto one of the port's registers.
package io_port_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned ST_CNT_W = 4;

    // Register map: base address plus per-register word offsets
    localparam logic [ADDR_W-1:0] IO_START      = 16'h00F0;
    localparam logic [ADDR_W-1:0] IO_TX_OFS     = 16'd0;
    localparam logic [ADDR_W-1:0] IO_RX_OFS     = 16'd1;
    localparam logic [ADDR_W-1:0] IO_STATUS_OFS = 16'd2;
    localparam logic [ADDR_W-1:0] IO_TX         = IO_START + IO_TX_OFS;
    localparam logic [ADDR_W-1:0] IO_RX         = IO_START + IO_RX_OFS;
    localparam logic [ADDR_W-1:0] IO_STATUS     = IO_START + IO_STATUS_OFS;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_TX,
        SEL_RX,
        SEL_STATUS
    } io_sel_e;

    // STATUS word; fields listed MSB first, so tx_full lands on bit 0
    typedef struct packed {
        logic [1:0]          rsvd;
        logic                rx_unf;
        logic                tx_ovf;
        logic [ST_CNT_W-1:0] rx_count;
        logic [ST_CNT_W-1:0] tx_count;
        logic                rx_empty;
        logic                rx_full;
        logic                tx_empty;
        logic                tx_full;
    } io_status_t;

    function automatic io_sel_e decode_addr(input logic [ADDR_W-1:0] addr);
        io_sel_e sel;
        sel = SEL_NONE;
        if (addr == IO_TX)          sel = SEL_TX;
        else if (addr == IO_RX)     sel = SEL_RX;
        else if (addr == IO_STATUS) sel = SEL_STATUS;
        return sel;
    endfunction

endpackage

// File: rtl/io_port_if.sv
// Bus request and TX/RX stream handshake signals of the I/O port.
// The shared tri-state data bus stays a plain inout on the port itself.
interface io_port_if;
    import io_port_pkg::*;

    logic [ADDR_W-1:0] read_bus;
    logic              read_en;
    logic [ADDR_W-1:0] write_bus;
    logic              write_en;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output read_bus, read_en, write_bus, write_en, tx_ready, rx_data, rx_valid,
        input  tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  read_bus, read_en, write_bus, write_en, tx_ready, rx_data, rx_valid,
        output tx_data, tx_valid, rx_ready
    );

endinterface

// File: rtl/io_port_sync_fifo.sv
// Single-clock FIFO with occupancy count; head reads as zero while empty.
// Storage is not reset, only the pointers and the count.
module sync_fifo #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // A write landing on the same edge as reset must not leave a stored word behind
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_port.sv
// Memory-mapped I/O port: bus-writable TX queue, bus-readable RX queue and a
// STATUS register with sticky overflow/underflow flags, on a shared tri-state data bus.
module io_port
    import io_port_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [DATA_W-1:0] data_bus,
    io_port_if.slave          bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    io_sel_e           rd_sel;
    io_sel_e           wr_sel;
    logic              rd_hit;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] rx_head;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [CNT_W-1:0]  tx_count, rx_count;
    logic              tx_push, tx_pop, rx_push, rx_pop;
    logic              tx_ovf, rx_unf;
    logic              tx_ovf_set, rx_unf_set, flag_clr;
    io_status_t        status;

    assign rd_sel = bus.read_en  ? decode_addr(bus.read_bus)  : SEL_NONE;
    assign wr_sel = bus.write_en ? decode_addr(bus.write_bus) : SEL_NONE;

    assign tx_push    = (wr_sel == SEL_TX) && !tx_full;
    assign tx_ovf_set = (wr_sel == SEL_TX) && tx_full;
    assign tx_pop     = !tx_empty && bus.tx_ready;
    assign rx_push    = bus.rx_valid && !rx_full;
    assign rx_pop     = (rd_sel == SEL_RX) && !rx_empty;
    assign rx_unf_set = (rd_sel == SEL_RX) && rx_empty;
    assign flag_clr   = (wr_sel == SEL_STATUS);

    assign bus.tx_valid = !tx_empty;
    assign bus.rx_ready = !rx_full;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (data_bus),
        .pop       (tx_pop),
        .head      (bus.tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (bus.rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_comb begin
        status          = '0;
        status.tx_full  = tx_full;
        status.tx_empty = tx_empty;
        status.rx_full  = rx_full;
        status.rx_empty = rx_empty;
        status.tx_count = ST_CNT_W'(tx_count);
        status.rx_count = ST_CNT_W'(rx_count);
        status.tx_ovf   = tx_ovf;
        status.rx_unf   = rx_unf;
    end

    // Read mux; an empty RX queue reads as zero because its head is gated
    always_comb begin
        rdata = '0;
        if (rd_sel == SEL_STATUS) begin
            rdata = status;
        end else if (rd_sel == SEL_RX) begin
            rdata = rx_head;
        end
    end

    assign rd_hit   = !reset && ((rd_sel == SEL_RX) || (rd_sel == SEL_STATUS));
    assign data_bus = rd_hit ? rdata : 'z;

    // Sticky error flags; a new event on the clearing edge keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            tx_ovf <= tx_ovf_set || (tx_ovf && !flag_clr);
            rx_unf <= rx_unf_set || (rx_unf && !flag_clr);
        end
    end

endmodule
